inst_encoder: RTL and testbench

Instruction encoder and program loader: the inverse of the main control decoder. It accepts instruction requests (kind plus register and immediate fields) over a valid/ready handshake and encodes each one into a 32-bit MIPS word. The words are written sequentially into instruction memory, and a `finish` request closes the program with a self-jump halt word. It sits between the bench or boot sequencer and the instruction-memory write port, so programs can be built without hand-assembled hex.

---
 rtl/inst_encoder.sv | 143 ++++++++++++++
 tb/tb_inst_encoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Purpose: encodes instruction requests into 32-bit MIPS words and loads them into instruction memory, closing with a self-jump halt.
// Latency: write strobe one cycle after accept; halt strobe one cycle after finish is sampled; done one cycle after the halt strobe.
// Backpressure: reqReady is low during WRITE/HALT, in DONE, while reset is high, and when only the halt slot remains.
module inst_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [2:0]            reqKind,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [5:0]            funct,
  input  logic [15:0]           imm,
  input  logic [25:0]           target,
  input  logic                  finish,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memData,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  error,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HALT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Request kind codes as seen on reqKind.
  localparam logic [2:0] KIND_R   = 3'd0;
  localparam logic [2:0] KIND_LW  = 3'd1;
  localparam logic [2:0] KIND_SW  = 3'd2;
  localparam logic [2:0] KIND_BEQ = 3'd3;
  localparam logic [2:0] KIND_J   = 3'd4;

  // Primary opcodes placed in bits 31:26.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // The topmost word is kept free so the halt can always be written.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] wrPtrNext;
  logic [ADDR_WIDTH:0]   countNext;
  logic [31:0]           encWord;
  logic [31:0]           haltWord;
  logic                  kindLegal;
  logic                  accept;

  // Encode the presented request; unused fields of a kind are simply not wired into its word.
  always_comb begin
    encWord   = 32'd0;
    kindLegal = 1'b1;
    case (reqKind)
      KIND_R:   encWord = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_LW:  encWord = {OP_LW, rs, rt, imm};
      KIND_SW:  encWord = {OP_SW, rs, rt, imm};
      KIND_BEQ: encWord = {OP_BEQ, rs, rt, imm};
      KIND_J:   encWord = {OP_J, target};
      default:  kindLegal = 1'b0;
    endcase
  end

  // Halt is a jump whose target is its own word address, so the core spins there forever.
  assign haltWord  = {OP_J, 26'(wrPtr)};
  assign wrPtrNext = wrPtr + ADDR_WIDTH'(1);
  assign countNext = count + (ADDR_WIDTH + 1)'(1);

  // Ready only in IDLE with a user slot left; forced low while reset is held.
  assign reqReady = !reset && (state == IDLE) && !full;
  assign accept   = reqValid && reqReady;

  // Loader FSM: accept/encode in IDLE, strobe in WRITE/HALT, then park in DONE until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wrPtr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      error    <= 1'b0;
      done     <= 1'b0;
      memWrite <= 1'b0;
      memAddr  <= '0;
      memData  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // An accepted request wins over finish; finish is looked at again next IDLE cycle.
            if (kindLegal) begin
              memWrite <= 1'b1;
              memAddr  <= wrPtr;
              memData  <= encWord;
              state    <= WRITE;
            end else begin
              // Illegal kinds complete the handshake but leave memory untouched.
              error <= 1'b1;
            end
          end else if (finish) begin
            memWrite <= 1'b1;
            memAddr  <= wrPtr;
            memData  <= haltWord;
            state    <= HALT;
          end
        end
        WRITE: begin
          memWrite <= 1'b0;
          wrPtr    <= wrPtrNext;
          count    <= countNext;
          full     <= (wrPtrNext == LAST_ADDR);
          state    <= IDLE;
        end
        HALT: begin
          // wrPtr stays put: the halt may occupy the last slot and there is nothing after it.
          memWrite <= 1'b0;
          count    <= countNext;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          memWrite <= 1'b0;
        end
        default: begin
          memWrite <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Purpose: directed-vector bench for inst_encoder, run on an 8-bit and a 2-bit address instance in parallel.
// Latency: a cycle model predicts every output each cycle; literal checks pin the model at key points.
// Backpressure: stimulus holds reqValid until the large instance shows reqReady, with a bounded wait.
module tb_inst_encoder;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        reqValid = 1'b0;
  logic [2:0]  reqKind  = 3'd0;
  logic [4:0]  rs       = 5'd0;
  logic [4:0]  rt       = 5'd0;
  logic [4:0]  rd       = 5'd0;
  logic [4:0]  shamt    = 5'd0;
  logic [5:0]  funct    = 6'd0;
  logic [15:0] imm      = 16'd0;
  logic [25:0] target   = 26'd0;
  logic        finish   = 1'b0;

  logic        rdyB, wrB, fullB, errB, doneB;
  logic [7:0]  addrB;
  logic [31:0] dataB;
  logic [8:0]  cntB;
  logic        rdyS, wrS, fullS, errS, doneS;
  logic [1:0]  addrS;
  logic [31:0] dataS;
  logic [2:0]  cntS;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_WIDTH(8)) dutB (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(rdyB), .reqKind(reqKind),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .finish(finish), .memWrite(wrB), .memAddr(addrB), .memData(dataB), .count(cntB),
    .full(fullB), .error(errB), .done(doneB)
  );

  inst_encoder #(.ADDR_WIDTH(2)) dutS (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(rdyS), .reqKind(reqKind),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .finish(finish), .memWrite(wrS), .memAddr(addrS), .memData(dataS), .count(cntS),
    .full(fullS), .error(errS), .done(doneS)
  );

  // ---------------- behavioural model ----------------
  // Per instance: user words stored, whether the halt is in memory, sticky error,
  // and the strobe (if any) the DUT must show in the current cycle.
  int          cap [2] = '{256, 4};
  int          mUser [2];
  bit          mHalted [2];
  bit          mErr [2];
  bit          eWrite [2];
  bit          eHalt [2];
  int          eAddr [2];
  logic [31:0] eData [2];

  function automatic logic [31:0] encode();
    case (reqKind)
      3'd0:    return {6'b000000, rs, rt, rd, shamt, funct};
      3'd1:    return {6'b100011, rs, rt, imm};
      3'd2:    return {6'b101011, rs, rt, imm};
      3'd3:    return {6'b000100, rs, rt, imm};
      3'd4:    return {6'b000010, target};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      mUser[i] = 0; mHalted[i] = 0; mErr[i] = 0; eWrite[i] = 0; eHalt[i] = 0;
      eAddr[i] = 0; eData[i] = 32'd0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mUser[i] <= 0; mHalted[i] <= 0; mErr[i] <= 0; eWrite[i] <= 0; eHalt[i] <= 0;
      end else if (eWrite[i]) begin
        // the strobe cycle ends: the word is now counted
        if (eHalt[i]) mHalted[i] <= 1;
        else          mUser[i]   <= mUser[i] + 1;
        eWrite[i] <= 0;
      end else if (!mHalted[i]) begin
        if (reqValid && mUser[i] != cap[i] - 1) begin
          if (reqKind <= 3'd4) begin
            eWrite[i] <= 1; eHalt[i] <= 0; eAddr[i] <= mUser[i]; eData[i] <= encode();
          end else begin
            mErr[i] <= 1;
          end
        end else if (finish) begin
          eWrite[i] <= 1; eHalt[i] <= 1; eAddr[i] <= mUser[i];
          eData[i]  <= {6'b000010, 26'(mUser[i])};
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmpInst(input int i, input logic wr, input logic rdy, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] cnt, input logic fl,
                         input logic er, input logic dn);
    string tag;
    tag = (i == 0) ? "big" : "small";
    check({tag, ".memWrite"}, 32'(wr), 32'(eWrite[i]));
    check({tag, ".reqReady"}, 32'(rdy),
          32'(!reset && !eWrite[i] && !mHalted[i] && mUser[i] != cap[i] - 1));
    check({tag, ".count"}, cnt, 32'(mUser[i] + int'(mHalted[i])));
    check({tag, ".full"}, 32'(fl), 32'(mUser[i] == cap[i] - 1));
    check({tag, ".error"}, 32'(er), 32'(mErr[i]));
    check({tag, ".done"}, 32'(dn), 32'(mHalted[i]));
    if (eWrite[i]) begin
      check({tag, ".memAddr"}, addr, 32'(eAddr[i]));
      check({tag, ".memData"}, data, eData[i]);
    end
  endtask

  // Compare every cycle on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    cmpInst(0, wrB, rdyB, 32'(addrB), dataB, 32'(cntB), fullB, errB, doneB);
    cmpInst(1, wrS, rdyS, 32'(addrS), dataS, 32'(cntS), fullS, errS, doneS);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    reqValid = 1'b0;
    finish   = 1'b0;
    reset    = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic setReq(input logic [2:0] k, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [5:0] f, input logic [15:0] im,
                        input logic [25:0] tg);
    reqKind = k; rs = a; rt = b; rd = c; shamt = 5'd0; funct = f; imm = im; target = tg;
    reqValid = 1'b1;
  endtask

  // Present a request, wait (bounded) for ready, let the accepting edge pass,
  // and return in the cycle right after acceptance.
  task automatic send(input logic [2:0] k, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [5:0] f, input logic [15:0] im,
                      input logic [25:0] tg);
    int n;
    setReq(k, a, b, c, f, im, tg);
    n = 0;
    #1;
    while (!rdyB && n < 20) begin
      cyc();
      #1;
      n++;
    end
    if (!rdyB) begin
      total++;
      bad++;
      $display("FAIL send_timeout: reqReady=%b want 1", rdyB);
    end
    cyc();
    reqValid = 1'b0;
  endtask

  initial begin
    // watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc();
    cyc();
    check("rst.memWrite", 32'(wrB), 32'd0);
    check("rst.memAddr", 32'(addrB), 32'd0);
    check("rst.memData", dataB, 32'd0);
    check("rst.count", 32'(cntB), 32'd0);
    check("rst.flags", {29'd0, fullB, errB, doneB}, 32'd0);
    check("rst.reqReady", 32'(rdyB), 32'd0);
    reset = 1'b0;

    // lw rs=1 rt=2 imm=4
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 26'd0);
    check("lw.strobe", 32'(wrB), 32'd1);
    check("lw.addr", 32'(addrB), 32'd0);
    check("lw.data", dataB, 32'h8C220004);
    cyc();
    check("lw.count", 32'(cntB), 32'd1);

    // Mixed back-to-back sequence
    doReset();
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
    check("mix.r.data", dataB, 32'h00221820);
    check("mix.r.addr", 32'(addrB), 32'd0);
    check("mix.r.busy", 32'(rdyB), 32'd0);
    send(3'd2, 5'd0, 5'd3, 5'd0, 6'd0, 16'd8, 26'd0);
    check("mix.sw.data", dataB, 32'hAC030008);
    check("mix.sw.addr", 32'(addrB), 32'd1);
    send(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    check("mix.beq.data", dataB, 32'h1022FFFF);
    check("mix.beq.addr", 32'(addrB), 32'd2);
    cyc();
    check("mix.count", 32'(cntB), 32'd3);

    // Halt after two writes
    doReset();
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
    send(3'd2, 5'd0, 5'd3, 5'd0, 6'd0, 16'd8, 26'd0);
    cyc();
    finish = 1'b1;
    cyc();
    check("halt.strobe", 32'(wrB), 32'd1);
    check("halt.addr", 32'(addrB), 32'd2);
    check("halt.data", dataB, 32'h08000002);
    finish = 1'b0;
    setReq(3'd0, 5'd4, 5'd5, 5'd6, 6'h21, 16'd0, 26'd0);
    cyc();
    check("halt.count", 32'(cntB), 32'd3);
    check("halt.done", 32'(doneB), 32'd1);
    cyc();
    cyc();
    check("halt.ignored", 32'(wrB), 32'd0);
    check("halt.count2", 32'(cntB), 32'd3);
    reqValid = 1'b0;

    // Illegal kind, then j at the unchanged address
    doReset();
    send(3'd6, 5'd1, 5'd1, 5'd1, 6'd0, 16'd0, 26'd0);
    check("ill.nostrobe", 32'(wrB), 32'd0);
    check("ill.error", 32'(errB), 32'd1);
    send(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
    check("ill.j.addr", 32'(addrB), 32'd0);
    check("ill.j.data", dataB, 32'h08000010);
    cyc();
    check("ill.sticky", 32'(errB), 32'd1);

    // Full with the 2-bit instance
    doReset();
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 26'd0);
    send(3'd2, 5'd0, 5'd3, 5'd0, 6'd0, 16'd8, 26'd0);
    cyc();
    check("full.flag", 32'(fullS), 32'd1);
    check("full.ready", 32'(rdyS), 32'd0);
    finish = 1'b1;
    cyc();
    check("full.halt.strobe", 32'(wrS), 32'd1);
    check("full.halt.addr", 32'(addrS), 32'd3);
    check("full.halt.data", dataS, 32'h08000003);
    finish = 1'b0;
    cyc();
    check("full.count", 32'(cntS), 32'd4);

    // finish and a request together: request first, then halt
    doReset();
    setReq(3'd1, 5'd5, 5'd6, 5'd0, 6'd0, 16'h0010, 26'd0);
    finish = 1'b1;
    cyc();
    reqValid = 1'b0;
    check("col.req.data", dataB, 32'h8CA60010);
    check("col.req.addr", 32'(addrB), 32'd0);
    cyc();
    check("col.gap", 32'(wrB), 32'd0);
    cyc();
    check("col.halt.addr", 32'(addrB), 32'd1);
    check("col.halt.data", dataB, 32'h08000001);
    finish = 1'b0;
    cyc();
    check("col.count", 32'(cntB), 32'd2);

    // Reset during WRITE cancels the write
    doReset();
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 26'd0);
    check("rmid.inwrite", 32'(wrB), 32'd1);
    reset = 1'b1;
    cyc();
    check("rmid.strobe", 32'(wrB), 32'd0);
    check("rmid.count", 32'(cntB), 32'd0);
    check("rmid.data", dataB, 32'd0);
    reset = 1'b0;
    cyc();
    cyc();
    check("rmid.after", 32'(wrB), 32'd0);
    check("rmid.count2", 32'(cntB), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
